// File: rtl/conv_scan_ctrl_pkg.sv
// conv_scan_ctrl_pkg: shared constants and the scan FSM state encoding for the
// 3x3 convolution front-end sequencer.
package conv_scan_ctrl_pkg;

  // Pixel width of the convolution data path (the sequencer passes it through)
  localparam int unsigned DATA_WIDTH     = 8;

  // Default frame geometry
  localparam int unsigned DEF_IMG_WIDTH  = 28;
  localparam int unsigned DEF_IMG_HEIGHT = 28;

  // Frame sequencer states
  typedef enum logic [2:0] {
    SCAN_IDLE  = 3'd0,
    SCAN_CLEAR = 3'd1,
    SCAN_FILL  = 3'd2,
    SCAN_RUN   = 3'd3,
    SCAN_DRAIN = 3'd4
  } scan_state_e;

endpackage

// File: rtl/tag_delay.sv
// tag_delay: DEPTH-stage shift register of WIDTH-bit tags with a synchronous
// clear. It advances every cycle, and dout is the output of stage DEPTH-1.
// Ports: clk, clr (synchronous clear of all stages), din (tag in), dout (tag out).
module tag_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  // Shift by one stage per cycle
  always_comb begin
    pipe_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: frame sequencer for the 3x3 convolution front end. It gates
// the pixel stream into line_buffer, tracks the raster position of each accepted
// pixel, pulses the line/window buffer clear, and qualifies which windows leaving
// window_buffer are geometrically valid.
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   start               frame start request (honoured only in IDLE)
//   src_valid/src_ready pixel source handshake
//   lb_in_valid         accept strobe to line_buffer (combinational)
//   lb_clear            one-cycle clear pulse for the line/window buffers
//   win_keep/win_last   window qualifier and last-window flag
//   win_row/win_col     top-left coordinate of a kept window
//   busy, done          frame activity and completion pulse
//   stride2             only when CONV_STRIDE2_EN is defined: stride-2 window select
module conv_scan_ctrl
  import conv_scan_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int unsigned WIN_LAT    = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             src_valid,
`ifdef CONV_STRIDE2_EN
  input  logic             stride2,
`endif
  output logic             src_ready,
  output logic             lb_in_valid,
  output logic             lb_clear,
  output logic             win_keep,
  output logic             win_last,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             busy,
  output logic             done
);

  // Top-left coordinate of the last kept window for each stride
  localparam int unsigned LAST_R1 = IMG_HEIGHT - 3;
  localparam int unsigned LAST_C1 = IMG_WIDTH - 3;
  localparam int unsigned LAST_R2 = ((IMG_HEIGHT - 3) / 2) * 2;
  localparam int unsigned LAST_C2 = ((IMG_WIDTH - 3) / 2) * 2;

  // keep/last qualify the window; eof marks the final pixel of the frame
  typedef struct packed {
    logic             keep;
    logic             last;
    logic             eof;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             src_ready_q, src_ready_d;
  logic             lb_clear_q, lb_clear_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stride2_q;

  logic             accept;
  logic             col_end, row_end;
  logic [CNT_W-1:0] rel_row, rel_col;
  logic [CNT_W-1:0] last_row, last_col;
  logic             stride_ok;
  logic             tag_clr;
  tag_t             tag_in, tag_out;

`ifdef CONV_STRIDE2_EN
  logic stride2_d;

  // Stride select is captured once per frame while clearing
  always_comb begin
    stride2_d = stride2_q;
    if (state_q == SCAN_CLEAR) begin
      stride2_d = stride2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stride2_q <= 1'b0;
    end else begin
      stride2_q <= stride2_d;
    end
  end
`else
  assign stride2_q = 1'b0;
`endif

  assign accept      = src_valid & src_ready_q;
  assign lb_in_valid = accept;

  assign col_end = (col_q == CNT_W'(IMG_WIDTH - 1));
  assign row_end = (row_q == CNT_W'(IMG_HEIGHT - 1));
  assign rel_row = row_q - CNT_W'(2);
  assign rel_col = col_q - CNT_W'(2);

  assign stride_ok = ~stride2_q | (~rel_row[0] & ~rel_col[0]);
  assign last_row  = stride2_q ? CNT_W'(LAST_R2) : CNT_W'(LAST_R1);
  assign last_col  = stride2_q ? CNT_W'(LAST_C2) : CNT_W'(LAST_C1);

  // Tag for the pixel accepted this cycle; idle cycles insert an all-zero tag
  always_comb begin
    tag_in     = '0;
    tag_in.eof = accept & col_end & row_end;
    if (accept && (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2)) && stride_ok) begin
      tag_in.keep = 1'b1;
      tag_in.row  = rel_row;
      tag_in.col  = rel_col;
      tag_in.last = (rel_row == last_row) && (rel_col == last_col);
    end
  end

  assign tag_clr = reset | (state_q == SCAN_CLEAR);

  tag_delay #(
    .DEPTH (WIN_LAT),
    .WIDTH (TAG_W)
  ) u_tag_delay (
    .clk  (clk),
    .clr  (tag_clr),
    .din  (tag_in),
    .dout (tag_out)
  );

  // Next-state, raster counters and registered output values
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;

    unique case (state_q)
      SCAN_IDLE: begin
        if (start) begin
          state_d = SCAN_CLEAR;
        end
      end
      SCAN_CLEAR: begin
        row_d   = '0;
        col_d   = '0;
        state_d = SCAN_FILL;
      end
      SCAN_FILL, SCAN_RUN: begin
        if (accept) begin
          if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + CNT_W'(1);
          end else begin
            col_d = col_q + CNT_W'(1);
          end
          if ((state_q == SCAN_FILL) && (row_q >= CNT_W'(2))) begin
            state_d = SCAN_RUN;
          end
          if ((state_q == SCAN_RUN) && col_end && row_end) begin
            state_d = SCAN_DRAIN;
          end
        end
      end
      SCAN_DRAIN: begin
        // done is raised the cycle after the final tag leaves the pipe
        if (done_q) begin
          state_d = SCAN_IDLE;
        end else if (tag_out.eof) begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = SCAN_IDLE;
      end
    endcase

    src_ready_d = (state_d == SCAN_FILL) || (state_d == SCAN_RUN);
    lb_clear_d  = (state_d == SCAN_CLEAR);
    busy_d      = (state_d != SCAN_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      src_ready_q <= 1'b0;
      lb_clear_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      src_ready_q <= src_ready_d;
      lb_clear_q  <= lb_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign src_ready = src_ready_q;
  assign lb_clear  = lb_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign win_keep  = tag_out.keep;
  assign win_last  = tag_out.last;
  assign win_row   = tag_out.row;
  assign win_col   = tag_out.col;

endmodule

// File: doc/conv_scan_ctrl.md
# conv_scan_ctrl

Frame-level sequencer for the 3x3 convolution front end: it gates the pixel stream into `line_buffer`, tracks the raster position of every accepted pixel, and drives `window_buffer` flushing. It then qualifies which emitted 3x3 windows are geometrically valid, suppressing windows that straddle a row wrap or lie in the fill rows. It sits between the pixel source and `line_buffer`/`window_buffer` and feeds `win_keep`/`win_last` to the MAC array.

## Interface
- `DATA_WIDTH`, `` `DATA_WIDTH `` (from `cnn_params.vh`): pixel width, pass-through only.
- `IMG_WIDTH`, 28: pixels per row, ≥3.
- `IMG_HEIGHT`, 28: rows per frame, ≥3.
- `WIN_LAT`, 2: cycles from pixel accept (line_buffer `in_valid`) to the matching window on `window_buffer` outputs, ≥1.
- `CNT_W`, 8: row/column counter width, must hold max(IMG_WIDTH, IMG_HEIGHT)-1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle frame start request; honoured only in IDLE.
- `src_valid`  in  1  source pixel valid.
- `src_ready`  out  1  controller accepts pixels.
- `lb_in_valid`  out  1  to line_buffer `in_valid`; equals accept = `src_valid & src_ready` (combinational).
- `lb_clear`  out  1  one-cycle pulse, ORed into line/window buffer reset.
- `win_keep`  out  1  window on window_buffer outputs this cycle is valid.
- `win_last`  out  1  with `win_keep`: last window of frame.
- `win_row`, `win_col`  out  CNT_W each  top-left coordinate of kept window.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle frame-complete pulse.

## Operation
- States: IDLE, CLEAR, FILL, RUN, DRAIN.
- IDLE: `src_ready`=0. `start` → CLEAR.
- CLEAR: exactly one cycle with `lb_clear`=1, counters `row`=`col`=0, tag pipe cleared → FILL.
- FILL/RUN: `src_ready`=1. Each accept advances `col`; at `col`=IMG_WIDTH-1, `col`←0 and `row`++. No accept → counters hold, with no time-out.
- FILL → RUN on the first accept with `row`≥2. RUN → DRAIN on the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Tag per accept: `keep` = `row`≥2 and `col`≥2 (plus stride rule below), `r`=`row`-2, `c`=`col`-2, `last` = final pixel. Tags enter a WIN_LAT-deep shift register, which also advances on non-accept cycles with `keep`=0.
- The tap at depth WIN_LAT drives `win_keep`, `win_row`, `win_col`, `win_last`. When `win_keep`=0, `win_row`/`win_col`/`win_last` are 0.
- DRAIN: `src_ready`=0. Waits until the `last` tag exits the tap, then pulses `done` for one cycle → IDLE.
- Kept windows per frame (stride 1): (IMG_WIDTH-2)·(IMG_HEIGHT-2). Counters wrap only via the row rule; `row` never exceeds IMG_HEIGHT-1.
- `start` while `busy` is ignored, with no queuing.
- `reset` in any state → IDLE next edge, tag pipe cleared. No `done` and no `lb_clear` pulse is generated by reset.

## Timing
- Reset values: `src_ready`=0, `lb_clear`=0, `win_keep`=0, `win_last`=0, `win_row`=`win_col`=0, `busy`=0, `done`=0.
- `start` at edge N → `lb_clear`=1 in cycle N+1 → `src_ready`=1 from cycle N+2.
- The accept at cycle A produces `win_keep` (if tagged) in cycle A+WIN_LAT.
- `done` occurs one cycle after the `win_last` cycle. `busy` drops with the return to IDLE, in the cycle after `done`.
- Back-to-back frames: `start` is accepted in the cycle after `done`.

## Configuration
- `CONV_STRIDE2_EN` defined: adds input port `stride2` (1 bit), sampled in CLEAR and held for the frame. With `stride2`=1, `keep` additionally requires `row`-2 and `col`-2 both even, giving ⌈(W-2)/2⌉·⌈(H-2)/2⌉ windows. `win_last` marks the last kept window, which is not necessarily the last pixel's tag.
- Undefined: no port, stride fixed at 1.

## Structure
- `cnn_params.vh`: `DATA_WIDTH`, state encodings `SCAN_IDLE`..`SCAN_DRAIN`, default `IMG_WIDTH`/`IMG_HEIGHT`.
- One sub-module: `tag_delay` (parameterised depth/width shift register with synchronous clear) for the WIN_LAT tag pipe.

## Test plan
- 5x5 image, pixels 0..24, continuous `src_valid`, WIN_LAT=2 → exactly 9 `win_keep` pulses. First pulse has (`win_row`, `win_col`) = (0,0), 2 cycles after pixel 12 is accepted; the window_buffer shows [0 1 2/5 6 7/10 11 12]. Last pulse is (2,2) with `win_last`=1, followed by `done` one cycle later.
- The same frame with `src_valid` dropped for 3 cycles after pixels 4 and 13 → the same 9 windows in the same order, and no `win_keep` on windows straddling a row wrap (for example [3 4 5/…]).
- `reset` asserted after pixel 15 → all outputs at reset values next cycle. A new `start` then gives `lb_clear` and a full 9-window frame.
- `start` pulsed during RUN → ignored, with no extra `lb_clear`, and window count remains 9.
- With `CONV_STRIDE2_EN` and `stride2`=1 on the 5x5 frame → 4 windows at (0,0), (0,2), (2,0), (2,2), with `win_last` on (2,2).
- Two frames back-to-back (`start` the cycle after `done`) → 18 windows total and 2 `done` pulses.
